// File: rtl/reg_bank_pkg.sv
// reg_bank_pkg
// Shared definitions for the shadowed register bank and the EIM decoder:
// register offsets relative to BASE_ADDR, the commit FSM state type and
// the access-type encoding used on the EIM register port.
package reg_bank_pkg;

    localparam int OFF_STATUS      = 0;
    localparam int OFF_STICKY      = 1;
    localparam int OFF_IRQ_MASK    = 2;
    localparam int OFF_SHADOW_STAT = 3;
    localparam int OFF_CTRL_BASE   = 4;

    typedef enum logic {
        CS_IDLE,
        CS_PENDING
    } commit_state_t;

    // Bit 1 = write strobe, bit 0 = read strobe.
    typedef enum logic [1:0] {
        ACC_NONE       = 2'b00,
        ACC_READ       = 2'b01,
        ACC_WRITE      = 2'b10,
        ACC_READ_WRITE = 2'b11
    } acc_type_t;

    function automatic acc_type_t acc_decode(input logic rd, input logic wr);
        return acc_type_t'({wr, rd});
    endfunction

endpackage

// File: rtl/reg_bank_sticky.sv
// reg_bank_sticky
// Registers the level status inputs, captures rising edges into sticky
// bits (write-1-to-clear, a new rise beats a clear in the same cycle) and
// produces a registered, masked interrupt.
//
// Ports:
//   eim_clk, eim_rst_n  clock, async active-low reset
//   status_in           level status inputs
//   w1c                 clear mask from a STICKY write (0 when no write)
//   irq_mask            per-bit interrupt enable
//   status_q            registered status_in
//   sticky_q            captured rising edges
//   status_irq          |(sticky_q & irq_mask), registered
module reg_bank_sticky
    import reg_bank_pkg::*;
#(
    parameter int STAT_W = 8
) (
    input  logic              eim_clk,
    input  logic              eim_rst_n,
    input  logic [STAT_W-1:0] status_in,
    input  logic [STAT_W-1:0] w1c,
    input  logic [STAT_W-1:0] irq_mask,
    output logic [STAT_W-1:0] status_q,
    output logic [STAT_W-1:0] sticky_q,
    output logic              status_irq
);

    always_ff @(posedge eim_clk or negedge eim_rst_n) begin
        if (!eim_rst_n) begin
            status_q   <= '0;
            sticky_q   <= '0;
            status_irq <= 1'b0;
        end else begin
            status_q   <= status_in;
            // Rise term is OR'd after the clear so set wins.
            sticky_q   <= (sticky_q & ~w1c) | (status_in & ~status_q);
            status_irq <= |(sticky_q & irq_mask);
        end
    end

endmodule

// File: rtl/reg_bank_shadow.sv
// reg_bank_shadow
// Register bank for the detector control path. Control registers are
// double-buffered: writes land in a shadow copy and are promoted to the
// active copy (ctrl_out) together when commit_req arrives at a frame
// boundary. Also hosts status/sticky/irq-mask registers.
//
// Build option: REG_BANK_SHADOW_EN enables the shadow copy and commit FSM.
// Without it, control writes go straight to the active copy, shadow_pending
// is 0 and commit_req is only acknowledged.
//
// Ports:
//   eim_clk, eim_rst_n   clock, async active-low reset
//   reg_addr, reg_data   access address / write data
//   reg_data_index       write strobe
//   reg_read_index       read strobe
//   reg_read_out         read data, held until the next read
//   read_data_en         one-cycle read-valid pulse
//   addr_err             one-cycle pulse for an out-of-range access
//   status_in            level status inputs
//   status_irq           masked sticky interrupt
//   commit_req           frame-boundary commit request
//   commit_done          one-cycle commit acknowledge
//   shadow_pending       shadow written since the last commit
//   ctrl_out             active control values, reg k at [k*DATA_W +: DATA_W]
//
// Commit FSM:
//   state      | meaning
//   CS_IDLE    | shadow equals active
//   CS_PENDING | control write(s) since the last commit
module reg_bank_shadow
    import reg_bank_pkg::*;
#(
    parameter int                ADDR_W       = 16,
    parameter int                DATA_W       = 16,
    parameter int                NUM_CTRL     = 32,
    parameter int                STAT_W       = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR    = 16'h0100,
    parameter logic [DATA_W-1:0] CTRL_RST_VAL = '0
) (
    input  logic                       eim_clk,
    input  logic                       eim_rst_n,
    input  logic [ADDR_W-1:0]          reg_addr,
    input  logic [DATA_W-1:0]          reg_data,
    input  logic                       reg_data_index,
    input  logic                       reg_read_index,
    output logic [DATA_W-1:0]          reg_read_out,
    output logic                       read_data_en,
    output logic                       addr_err,
    input  logic [STAT_W-1:0]          status_in,
    output logic                       status_irq,
    input  logic                       commit_req,
    output logic                       commit_done,
    output logic                       shadow_pending,
    output logic [NUM_CTRL*DATA_W-1:0] ctrl_out
);

    logic [ADDR_W-1:0] offset;
    logic [ADDR_W-1:0] ctrl_idx;
    logic              in_range;
    logic              ctrl_hit;
    logic              ctrl_wr;
    logic              mask_wr;
    logic [STAT_W-1:0] sticky_w1c;
    logic [STAT_W-1:0] irq_mask_q;
    logic [STAT_W-1:0] status_q;
    logic [STAT_W-1:0] sticky_q;
    logic [DATA_W-1:0] rd_mux;
    acc_type_t         acc;

    logic [DATA_W-1:0] active_q [NUM_CTRL];

    always_comb begin
        acc      = acc_decode(reg_read_index, reg_data_index);
        offset   = reg_addr - BASE_ADDR;
        // The lower-bound test catches addresses below BASE_ADDR, which
        // would otherwise wrap to a large offset.
        in_range = (reg_addr >= BASE_ADDR) &&
                   (offset < ADDR_W'(OFF_CTRL_BASE + NUM_CTRL));
        ctrl_hit = in_range && (offset >= ADDR_W'(OFF_CTRL_BASE));
        ctrl_idx = offset - ADDR_W'(OFF_CTRL_BASE);
        ctrl_wr  = reg_data_index && ctrl_hit;
        mask_wr  = reg_data_index && in_range && (offset == ADDR_W'(OFF_IRQ_MASK));
        sticky_w1c = (reg_data_index && in_range && (offset == ADDR_W'(OFF_STICKY)))
                     ? reg_data[STAT_W-1:0] : '0;
    end

    reg_bank_sticky #(
        .STAT_W (STAT_W)
    ) u_sticky (
        .eim_clk    (eim_clk),
        .eim_rst_n  (eim_rst_n),
        .status_in  (status_in),
        .w1c        (sticky_w1c),
        .irq_mask   (irq_mask_q),
        .status_q   (status_q),
        .sticky_q   (sticky_q),
        .status_irq (status_irq)
    );

    always_ff @(posedge eim_clk or negedge eim_rst_n) begin
        if (!eim_rst_n) begin
            irq_mask_q <= '0;
        end else if (mask_wr) begin
            irq_mask_q <= reg_data[STAT_W-1:0];
        end
    end

`ifdef REG_BANK_SHADOW_EN
    logic [DATA_W-1:0] shadow_q [NUM_CTRL];
    commit_state_t     state_q;
    commit_state_t     state_nxt;
    logic              commit_apply;

    always_ff @(posedge eim_clk or negedge eim_rst_n) begin
        if (!eim_rst_n) begin
            state_q <= CS_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state_q;
        commit_apply = 1'b0;
        case (state_q)
            CS_IDLE: begin
                if (ctrl_wr) state_nxt = CS_PENDING;
            end
            CS_PENDING: begin
                commit_apply = commit_req;
                // A write coincident with the commit keeps us pending.
                if (commit_req && !ctrl_wr) state_nxt = CS_IDLE;
            end
            default: state_nxt = CS_IDLE;
        endcase
    end

    assign shadow_pending = (state_q == CS_PENDING);

    // Promotion copies the pre-write shadow, so a coincident control write
    // is held back for the next commit.
    always_ff @(posedge eim_clk or negedge eim_rst_n) begin
        if (!eim_rst_n) begin
            for (int k = 0; k < NUM_CTRL; k++) begin
                shadow_q[k] <= CTRL_RST_VAL;
                active_q[k] <= CTRL_RST_VAL;
            end
        end else begin
            for (int k = 0; k < NUM_CTRL; k++) begin
                if (ctrl_wr && (ctrl_idx == ADDR_W'(k))) shadow_q[k] <= reg_data;
                if (commit_apply) active_q[k] <= shadow_q[k];
            end
        end
    end
`else
    assign shadow_pending = 1'b0;

    always_ff @(posedge eim_clk or negedge eim_rst_n) begin
        if (!eim_rst_n) begin
            for (int k = 0; k < NUM_CTRL; k++) begin
                active_q[k] <= CTRL_RST_VAL;
            end
        end else begin
            for (int k = 0; k < NUM_CTRL; k++) begin
                if (ctrl_wr && (ctrl_idx == ADDR_W'(k))) active_q[k] <= reg_data;
            end
        end
    end
`endif

    always_comb begin
        ctrl_out = '0;
        for (int k = 0; k < NUM_CTRL; k++) begin
            ctrl_out[k*DATA_W +: DATA_W] = active_q[k];
        end
    end

    always_comb begin
        rd_mux = '0;
        if (in_range) begin
            if (offset == ADDR_W'(OFF_STATUS)) begin
                rd_mux = DATA_W'(status_q);
            end else if (offset == ADDR_W'(OFF_STICKY)) begin
                rd_mux = DATA_W'(sticky_q);
            end else if (offset == ADDR_W'(OFF_IRQ_MASK)) begin
                rd_mux = DATA_W'(irq_mask_q);
            end else if (offset == ADDR_W'(OFF_SHADOW_STAT)) begin
                rd_mux = DATA_W'(shadow_pending);
            end else begin
                for (int k = 0; k < NUM_CTRL; k++) begin
                    if (ctrl_idx == ADDR_W'(k)) begin
`ifdef REG_BANK_SHADOW_EN
                        rd_mux = shadow_q[k];
`else
                        rd_mux = active_q[k];
`endif
                    end
                end
            end
        end
    end

    always_ff @(posedge eim_clk or negedge eim_rst_n) begin
        if (!eim_rst_n) begin
            reg_read_out <= '0;
            read_data_en <= 1'b0;
            addr_err     <= 1'b0;
            commit_done  <= 1'b0;
        end else begin
            if (reg_read_index) reg_read_out <= rd_mux;
            read_data_en <= reg_read_index;
            addr_err     <= (acc != ACC_NONE) && !in_range;
            commit_done  <= commit_req;
        end
    end

endmodule

// File: tb/tb_reg_bank_shadow.sv
module tb_reg_bank_shadow;

    localparam int          ADDR_W   = 16;
    localparam int          DATA_W   = 16;
    localparam int          NUM_CTRL = 8;
    localparam int          STAT_W   = 8;
    localparam logic [15:0] BASE     = 16'h0100;
    localparam logic [15:0] RST_VAL  = 16'hA5C3;
    localparam int          CW       = NUM_CTRL * DATA_W;

    typedef logic [CW-1:0] val_t;

    logic              eim_clk = 1'b0;
    logic              eim_rst_n = 1'b0;
    logic [15:0]       reg_addr = '0;
    logic [15:0]       reg_data = '0;
    logic              reg_data_index = 1'b0;
    logic              reg_read_index = 1'b0;
    logic [15:0]       reg_read_out;
    logic              read_data_en;
    logic              addr_err;
    logic [7:0]        status_in = '0;
    logic              status_irq;
    logic              commit_req = 1'b0;
    logic              commit_done;
    logic              shadow_pending;
    logic [CW-1:0]     ctrl_out;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state
    logic [15:0] m_shadow [NUM_CTRL];
    logic [15:0] m_active [NUM_CTRL];
    logic        m_pend;
    logic [7:0]  m_stq, m_sticky, m_mask;
    logic        m_irq, m_rden, m_err, m_done;
    logic [15:0] m_rd;

    reg_bank_shadow #(
        .ADDR_W       (ADDR_W),
        .DATA_W       (DATA_W),
        .NUM_CTRL     (NUM_CTRL),
        .STAT_W       (STAT_W),
        .BASE_ADDR    (BASE),
        .CTRL_RST_VAL (RST_VAL)
    ) dut (
        .eim_clk        (eim_clk),
        .eim_rst_n      (eim_rst_n),
        .reg_addr       (reg_addr),
        .reg_data       (reg_data),
        .reg_data_index (reg_data_index),
        .reg_read_index (reg_read_index),
        .reg_read_out   (reg_read_out),
        .read_data_en   (read_data_en),
        .addr_err       (addr_err),
        .status_in      (status_in),
        .status_irq     (status_irq),
        .commit_req     (commit_req),
        .commit_done    (commit_done),
        .shadow_pending (shadow_pending),
        .ctrl_out       (ctrl_out)
    );

    always #5 eim_clk = ~eim_clk;

    task automatic check_val(input string tag, input val_t obs, input val_t exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t got=%0h want=%0h", tag, $time, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NUM_CTRL; k++) begin
            m_shadow[k] = RST_VAL;
            m_active[k] = RST_VAL;
        end
        m_pend = 0; m_stq = 0; m_sticky = 0; m_mask = 0;
        m_irq = 0; m_rden = 0; m_err = 0; m_done = 0; m_rd = 0;
    endtask

    function automatic val_t m_ctrl_vec();
        val_t v = '0;
        for (int k = 0; k < NUM_CTRL; k++) v[k*16 +: 16] = m_active[k];
        return v;
    endfunction

    // Apply one clock of the register-bank rules to the model, using the
    // inputs held during the cycle that just ended.
    task automatic model_step();
        int          off;
        bit          inr, is_ctrl, wr, rd;
        logic [15:0] rv;
        logic [7:0]  clr;
        off     = int'(reg_addr) - int'(BASE);
        inr     = (off >= 0) && (off < 4 + NUM_CTRL);
        is_ctrl = inr && (off >= 4);
        wr      = reg_data_index;
        rd      = reg_read_index;
        rv      = 16'h0;
        if (inr) begin
            case (off)
                0: rv = {8'h00, m_stq};
                1: rv = {8'h00, m_sticky};
                2: rv = {8'h00, m_mask};
                3: rv = {15'h0, m_pend};
                default: begin
`ifdef REG_BANK_SHADOW_EN
                    rv = m_shadow[off-4];
`else
                    rv = m_active[off-4];
`endif
                end
            endcase
        end
        if (rd) m_rd = rv;
        m_rden = rd;
        m_err  = (rd || wr) && !inr;
        m_done = commit_req;
        m_irq  = |(m_sticky & m_mask);
        clr    = (wr && inr && off == 1) ? reg_data[7:0] : 8'h00;
        m_sticky = (m_sticky & ~clr) | (status_in & ~m_stq);
        m_stq    = status_in;
        if (wr && inr && off == 2) m_mask = reg_data[7:0];
`ifdef REG_BANK_SHADOW_EN
        if (commit_req && m_pend)
            for (int k = 0; k < NUM_CTRL; k++) m_active[k] = m_shadow[k];
        if (wr && is_ctrl) m_shadow[off-4] = reg_data;
        if (wr && is_ctrl)   m_pend = 1;
        else if (commit_req) m_pend = 0;
`else
        if (wr && is_ctrl) m_active[off-4] = reg_data;
`endif
    endtask

    task automatic check_all();
        check_val("read_data_en",   val_t'(read_data_en),   val_t'(m_rden));
        check_val("addr_err",       val_t'(addr_err),       val_t'(m_err));
        check_val("commit_done",    val_t'(commit_done),    val_t'(m_done));
        check_val("shadow_pending", val_t'(shadow_pending), val_t'(m_pend));
        check_val("status_irq",     val_t'(status_irq),     val_t'(m_irq));
        check_val("reg_read_out",   val_t'(reg_read_out),   val_t'(m_rd));
        check_val("ctrl_out",       val_t'(ctrl_out),       m_ctrl_vec());
    endtask

    task automatic cyc(input logic [15:0] addr, input logic [15:0] data,
                       input logic wr, input logic rd, input logic cr,
                       input logic [7:0] st);
        reg_addr = addr; reg_data = data;
        reg_data_index = wr; reg_read_index = rd;
        commit_req = cr; status_in = st;
        @(posedge eim_clk);
        #1;
        model_step();
        check_all();
    endtask

    task automatic idle(input logic [7:0] st);
        cyc(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, st);
    endtask

    initial begin
        logic [15:0] a;
        model_reset();
        repeat (3) @(posedge eim_clk);
        #1;
        check_val("rst_ctrl_out", val_t'(ctrl_out), {NUM_CTRL{RST_VAL}});
        check_val("rst_rd_out",   val_t'(reg_read_out), val_t'(0));
        check_val("rst_pending",  val_t'(shadow_pending), val_t'(0));
        check_val("rst_done",     val_t'(commit_done), val_t'(0));
        eim_rst_n = 1'b1;
        idle(8'h00);

        // Read a control register and an out-of-range address.
        cyc(BASE + 16'd4, 16'h0, 1'b0, 1'b1, 1'b0, 8'h00);
        check_val("rd_ctrl_rst", val_t'(reg_read_out), val_t'(RST_VAL));
        check_val("rd_en_pulse", val_t'(read_data_en), val_t'(1));
        idle(8'h00);
        check_val("rd_en_drop", val_t'(read_data_en), val_t'(0));
        cyc(BASE + 16'h0200, 16'h0, 1'b0, 1'b1, 1'b0, 8'h00);
        check_val("rd_oor_data", val_t'(reg_read_out), val_t'(0));
        check_val("rd_oor_err",  val_t'(addr_err), val_t'(1));
        idle(8'h00);

        // Write, read back, commit.
        cyc(BASE + 16'd4, 16'h1234, 1'b1, 1'b0, 1'b0, 8'h00);
`ifdef REG_BANK_SHADOW_EN
        check_val("wr_ctrl_held",  val_t'(ctrl_out[15:0]), val_t'(RST_VAL));
        check_val("wr_pending",    val_t'(shadow_pending), val_t'(1));
`else
        check_val("wr_ctrl_direct", val_t'(ctrl_out[15:0]), val_t'(16'h1234));
`endif
        cyc(BASE + 16'd4, 16'h0, 1'b0, 1'b1, 1'b0, 8'h00);
        check_val("rd_back", val_t'(reg_read_out), val_t'(16'h1234));
        cyc(16'h0, 16'h0, 1'b0, 1'b0, 1'b1, 8'h00);
        check_val("commit_ctrl", val_t'(ctrl_out[15:0]), val_t'(16'h1234));
        check_val("commit_ack",  val_t'(commit_done), val_t'(1));
        check_val("commit_idle", val_t'(shadow_pending), val_t'(0));

        // Write coincident with commit is deferred.
        cyc(BASE + 16'd5, 16'hBEEF, 1'b1, 1'b0, 1'b1, 8'h00);
`ifdef REG_BANK_SHADOW_EN
        check_val("coinc_ctrl", val_t'(ctrl_out[31:16]), val_t'(RST_VAL));
        check_val("coinc_pend", val_t'(shadow_pending), val_t'(1));
`endif
        cyc(16'h0, 16'h0, 1'b0, 1'b0, 1'b1, 8'h00);
        check_val("commit2_ctrl", val_t'(ctrl_out[31:16]), val_t'(16'hBEEF));

        // Sticky capture, masked irq, W1C, set-beats-clear.
        cyc(BASE + 16'd2, 16'hFF04, 1'b1, 1'b0, 1'b0, 8'h00);
        cyc(16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 8'h05);
        check_val("irq_n1", val_t'(status_irq), val_t'(0));
        idle(8'h05);
        check_val("irq_n2", val_t'(status_irq), val_t'(1));
        cyc(BASE + 16'd1, 16'h0, 1'b0, 1'b1, 1'b0, 8'h05);
        check_val("sticky_rd", val_t'(reg_read_out), val_t'(16'h0005));
        cyc(BASE + 16'd1, 16'h0004, 1'b1, 1'b0, 1'b0, 8'h01);
        idle(8'h01);
        check_val("irq_clr", val_t'(status_irq), val_t'(0));
        idle(8'h01);
        cyc(BASE + 16'd1, 16'h0004, 1'b1, 1'b0, 1'b0, 8'h05);
        cyc(BASE + 16'd1, 16'h0, 1'b0, 1'b1, 1'b0, 8'h05);
        check_val("sticky_set_wins", val_t'(reg_read_out), val_t'(16'h0005));

        // Randomised traffic.
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 19) == 0) a = 16'($urandom);
            else a = BASE - 16'd2 + 16'($urandom_range(0, NUM_CTRL + 7));
            cyc(a, 16'($urandom),
                1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 5) == 0), 8'($urandom));
        end

        // Mid-operation reset with a pending shadow write.
        cyc(BASE + 16'd6, 16'h7777, 1'b1, 1'b0, 1'b0, 8'h00);
        cyc(BASE + 16'd7, 16'h8888, 1'b1, 1'b0, 1'b0, 8'h00);
        eim_rst_n = 1'b0;
        #2;
        model_reset();
        check_val("mid_rst_ctrl", val_t'(ctrl_out), {NUM_CTRL{RST_VAL}});
        check_val("mid_rst_pend", val_t'(shadow_pending), val_t'(0));
        check_val("mid_rst_irq",  val_t'(status_irq), val_t'(0));
        check_val("mid_rst_rden", val_t'(read_data_en), val_t'(0));
        @(posedge eim_clk);
        #1;
        eim_rst_n = 1'b1;
        cyc(BASE + 16'd10, 16'h0, 1'b0, 1'b1, 1'b0, 8'h00);
        check_val("mid_rst_shadow", val_t'(reg_read_out), val_t'(RST_VAL));

        // Back-to-back commits each acknowledged.
        for (int i = 0; i < 3; i++) begin
            cyc(16'h0, 16'h0, 1'b0, 1'b0, 1'b1, 8'h00);
            check_val("b2b_done", val_t'(commit_done), val_t'(1));
        end
        idle(8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
